avalon_read_arbiter: RTL and testbench
======================================

// Module: avalon_read_arbiter
// PURPOSE
//  Round-robin arbiter sharing one read-only Avalon-MM slave (e.g. sysid/ID/status regs) among
//  NUM_MASTERS requesters. One transaction in flight at a time. Sits between the masters and the shared slave.
// PARAMETERS
//  NUM_MASTERS     2    requesters, 2..8
//  ADDR_W          1    slave address width
//  DATA_W          32   read data width
//  TIMEOUT_CYCLES  255  ISSUE-state cycle limit; used only with ARB_TIMEOUT_EN
// PORTS
//  clock          in   1                   system clock, all logic on rising edge
//  reset          in   1                   asynchronous, active-high reset
//  m_read         in   NUM_MASTERS         per-master read request, held until own waitrequest low
//  m_address      in   NUM_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
//  m_waitrequest  out  NUM_MASTERS         per-master stall; low exactly one cycle on completion
//  m_readdata     out  DATA_W              shared return bus, valid for master i when m_waitrequest[i]=0
//  s_read         out  1                   slave read strobe
//  s_address      out  ADDR_W              slave address (registered)
//  s_readdata     in   DATA_W              slave read data
//  s_waitrequest  in   1                   slave stall (tie 0 for zero-wait slaves)
//  grant          out  NUM_MASTERS         one-hot current owner, 0 in IDLE
//  timeout_err    out  1                   sticky timeout flag
// BEHAVIOUR
//  Reset values: state=IDLE, s_read=0, s_address=0, m_readdata=0, m_waitrequest=all 1, grant=0,
//   last_grant=NUM_MASTERS-1 (master 0 has priority first), timeout_err=0. Reset mid-transaction aborts
//   immediately: s_read drops asynchronously, no completion is signalled.
//  FSM:
//   IDLE : if any m_read, select winner = first requester searching upward from last_grant+1 (mod N);
//          latch its address into s_address, set grant -> ISSUE. No request: stay.
//   ISSUE: s_read=1. When s_waitrequest=0, capture s_readdata into m_readdata -> DONE.
//   DONE : m_waitrequest[winner]=0 for this cycle only; last_grant<=winner; grant<=0 -> IDLE.
//  Latency: request sampled in cycle 0, slave strobed in cycle 1, response in cycle 2 (zero-wait slave):
//   3 cycles per read, next arbitration in cycle 3. Each slave wait cycle adds 1.
//  m_waitrequest[i]=1 in every state except DONE for the winner, including when m_read[i]=0.
//  Simultaneous requests: round-robin. Last winner has lowest priority in the next arbitration.
//   The winner re-requesting back-to-back loses to any other pending requester.
//  Master deasserts m_read mid-transaction (protocol violation): transaction completes, DONE pulse still
//   issued, data discarded by the master. No retry.
//  m_address/m_read changes after IDLE are ignored. s_address holds until the next grant.
//  m_readdata holds its last value outside DONE.
// CONFIGURATION
//  `ARB_TIMEOUT_EN defined: ISSUE counts cycles with s_waitrequest=1. On reaching TIMEOUT_CYCLES, drop
//   s_read, return all-ones data, go to DONE and set timeout_err (cleared only by reset).
//  Not defined: ISSUE waits indefinitely. timeout_err tied 0. No counter logic.
// STRUCTURE
//  Package avalon_arb_pkg: state enum {IDLE, ISSUE, DONE}, state width constant, ALL_ONES data constant.
//  Sub-module rr_priority_picker: combinational req vector + last_grant index -> one-hot winner + index.
//   Instantiated once. The FSM, registers and timeout counter stay in this module.
// TESTING
//  Model slave returns 32'h5AA6A85A at addr 1 and 32'h0 at addr 0, with 0 wait states.
//  1 Single: m0 reads addr 1 -> s_read in cycle 1, m_waitrequest[0]=0 in cycle 2, m_readdata=5AA6A85A.
//  2 Contention: m0 and m1 request in the same cycle after reset -> m0 served first (cycle 2),
//    m1 second (cycle 5). Repeat immediately -> m0 then m1 again.
//  3 Fairness: m0 and m1 hold read continuously for 8 transactions -> grants alternate 0,1,0,1...
//    with no starvation.
//  4 Slave stall: s_waitrequest=1 for 4 cycles -> m_waitrequest stays 1, completion in cycle 6, correct data.
//  5 Reset mid-ISSUE: assert reset during the ISSUE cycle -> s_read=0 asynchronously, all waitrequest=1,
//    next request after release is served normally by master 0.
//  6 With ARB_TIMEOUT_EN: TIMEOUT_CYCLES=8 and s_waitrequest stuck at 1 -> DONE after 8 ISSUE cycles,
//    m_readdata=FFFFFFFF, timeout_err=1 and stays set.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared state encoding, constants and helpers for the Avalon read arbiter.
package avalon_arb_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned MAX_DATA_W = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = STATE_W'(0),
    ISSUE = STATE_W'(1),
    DONE  = STATE_W'(2)
  } arb_state_e;

  // Read data returned to the owner when a slave access is abandoned.
  localparam logic [MAX_DATA_W-1:0] ALL_ONES = '1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalon_read_arbiter_if.sv
// Signal bundle between the requesting masters, the read arbiter and the shared read-only slave.
interface avalon_read_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 1,
  parameter int unsigned DATA_W      = 32
);

  logic [NUM_MASTERS-1:0]        m_read;
  logic [NUM_MASTERS*ADDR_W-1:0] m_address;
  logic [NUM_MASTERS-1:0]        m_waitrequest;
  logic [DATA_W-1:0]             m_readdata;
  logic                          s_read;
  logic [ADDR_W-1:0]             s_address;
  logic [DATA_W-1:0]             s_readdata;
  logic                          s_waitrequest;

  modport arb (
    input  m_read, m_address, s_readdata, s_waitrequest,
    output m_waitrequest, m_readdata, s_read, s_address
  );

  modport master (
    output m_read, m_address,
    input  m_waitrequest, m_readdata
  );

  modport slave (
    input  s_read, s_address,
    output s_readdata, s_waitrequest
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first requester searching upward from last_grant+1 (mod N).
module rr_priority_picker #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] winner_onehot_c,
  output logic [IDX_W-1:0]       winner_idx_c,
  output logic                   valid_c
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand            = '0;
    winner_onehot_c = '0;
    winner_idx_c    = '0;
    valid_c         = 1'b0;
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_MASTERS);
      if (!valid_c && req[cand]) begin
        valid_c               = 1'b1;
        winner_idx_c          = cand;
        winner_onehot_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avalon_read_arbiter.sv
// Round-robin arbiter giving NUM_MASTERS requesters one-at-a-time reads of a shared read-only slave.
// Optional ARB_TIMEOUT_EN: abandon a slave access after TIMEOUT_CYCLES stalled cycles.
module avalon_read_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = 1,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  avalon_read_arbiter_if.arb     bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   timeout_err
);

  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

  arb_state_e             state, state_d;
  logic [IDX_W-1:0]       winner, winner_d;
  logic [IDX_W-1:0]       last_grant, last_grant_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [NUM_MASTERS-1:0] m_waitrequest_q, m_waitrequest_d;
  logic [DATA_W-1:0]      m_readdata_q, m_readdata_d;
  logic                   s_read_q, s_read_d;
  logic [ADDR_W-1:0]      s_address_q, s_address_d;

  logic [NUM_MASTERS-1:0] pick_onehot_c;
  logic [IDX_W-1:0]       pick_idx_c;
  logic                   pick_valid_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt, stall_cnt_d;
  logic             timeout_q, timeout_d;
`else
  logic timeout_param_unused;
  assign timeout_param_unused = (TIMEOUT_CYCLES == 0);
`endif

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req             (bus.m_read),
    .last_grant      (last_grant),
    .winner_onehot_c (pick_onehot_c),
    .winner_idx_c    (pick_idx_c),
    .valid_c         (pick_valid_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state;
    winner_d        = winner;
    last_grant_d    = last_grant;
    grant_d         = grant;
    s_read_d        = s_read_q;
    s_address_d     = s_address_q;
    m_readdata_d    = m_readdata_q;
    m_waitrequest_d = '1;
`ifdef ARB_TIMEOUT_EN
    stall_cnt_d     = stall_cnt;
    timeout_d       = timeout_q;
`endif
    case (state)
      IDLE: begin
        if (pick_valid_c) begin
          winner_d    = pick_idx_c;
          grant_d     = pick_onehot_c;
          s_address_d = bus.m_address[pick_idx_c*ADDR_W +: ADDR_W];
          s_read_d    = 1'b1;
          state_d     = ISSUE;
`ifdef ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      ISSUE: begin
        if (!bus.s_waitrequest) begin
          m_readdata_d            = bus.s_readdata;
          s_read_d                = 1'b0;
          m_waitrequest_d[winner] = 1'b0;
          state_d                 = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          m_readdata_d            = DATA_W'(ALL_ONES);
          s_read_d                = 1'b0;
          m_waitrequest_d[winner] = 1'b0;
          timeout_d               = 1'b1;
          state_d                 = DONE;
        end else begin
          stall_cnt_d = stall_cnt + 1'b1;
        end
`endif
      end
      DONE: begin
        last_grant_d = winner;
        grant_d      = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any transfer in flight without a completion pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      winner          <= '0;
      last_grant      <= IDX_W'(NUM_MASTERS - 1);
      grant           <= '0;
      s_read_q        <= 1'b0;
      s_address_q     <= '0;
      m_readdata_q    <= '0;
      m_waitrequest_q <= '1;
    end else begin
      state           <= state_d;
      winner          <= winner_d;
      last_grant      <= last_grant_d;
      grant           <= grant_d;
      s_read_q        <= s_read_d;
      s_address_q     <= s_address_d;
      m_readdata_q    <= m_readdata_d;
      m_waitrequest_q <= m_waitrequest_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign bus.s_read        = s_read_q;
  assign bus.s_address     = s_address_q;
  assign bus.m_readdata    = m_readdata_q;
  assign bus.m_waitrequest = m_waitrequest_q;

endmodule

// File: tb/tb_avalon_read_arbiter.sv
// Bench for avalon_read_arbiter: transaction-level timeline model checked every cycle plus directed literal checks.
module tb_avalon_read_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 1;
  localparam int unsigned DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif
  localparam logic [DW-1:0] ID_WORD = 32'h5AA6A85A;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] grant;
  logic         timeout_err;

  avalon_read_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  avalon_read_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pending [N];
  int stall_cfg = 0;
  int stall_cnt = 0;

  // Timeline model of the transaction in flight.
  bit            txn_active = 1'b0;
  int            t_start, t_end, txn_win;
  int            last_win = N - 1;
  int            next_arb = 0;
  logic [AW-1:0] txn_addr, cur_addr;
  logic [DW-1:0] txn_data, cur_data;
  bit            txn_to, cur_to;
  logic [N-1:0]  exp_grant, exp_wr;
  logic          exp_sread;

  int            log_who [$];
  int            log_cyc [$];
  logic [DW-1:0] log_data [$];

  function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
    return (a == AW'(1)) ? ID_WORD : '0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, need %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Zero/configurable-wait slave returning a fixed ID word at address 1.
  always_comb begin
    bus.s_readdata    = slave_word(bus.s_address);
    bus.s_waitrequest = bus.s_read && (stall_cnt < stall_cfg);
  end

  always @(posedge clock or posedge reset) begin
    if (reset)           stall_cnt <= 0;
    else if (bus.s_read) stall_cnt <= stall_cnt + 1;
    else                 stall_cnt <= 0;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Masters hold read while they still have reads outstanding.
  always @(posedge clock) begin
    logic [N-1:0] r;
    #1;
    r = '0;
    for (int i = 0; i < N; i++) if (pending[i] > 0) r = r | (N'(1) << i);
    bus.m_read = r;
  end

  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (((bus.m_waitrequest >> i) & N'(1)) == '0) begin
          if (pending[i] > 0) pending[i] = pending[i] - 1;
          log_who.push_back(i);
          log_cyc.push_back(cyc);
          log_data.push_back(bus.m_readdata);
        end
      end
    end
  end

  // Model update and per-cycle comparison.
  always @(negedge clock) begin
    int w;
    int c;
    if (reset) begin
      txn_active = 1'b0;
      last_win   = N - 1;
      next_arb   = 0;
      cur_addr   = '0;
      cur_data   = '0;
      cur_to     = 1'b0;
    end else begin
      if (txn_active && cyc == t_start + 1) cur_addr = txn_addr;
      if (txn_active && cyc == t_end) begin
        cur_data = txn_data;
        if (txn_to) cur_to = 1'b1;
      end
      exp_grant = '0;
      exp_wr    = '1;
      exp_sread = 1'b0;
      if (txn_active && cyc > t_start) begin
        exp_grant = N'(1) << txn_win;
        if (cyc < t_end) exp_sread = 1'b1;
      end
      if (txn_active && cyc == t_end) exp_wr = ~(N'(1) << txn_win);
      check("cmp_grant",     64'(grant),             64'(exp_grant));
      check("cmp_s_read",    64'(bus.s_read),        64'(exp_sread));
      check("cmp_s_address", 64'(bus.s_address),    64'(cur_addr));
      check("cmp_waitreq",   64'(bus.m_waitrequest), 64'(exp_wr));
      check("cmp_readdata",  64'(bus.m_readdata),    64'(cur_data));
      check("cmp_timeout",   64'(timeout_err),       64'(cur_to));
      if (txn_active && cyc == t_end) begin
        txn_active = 1'b0;
        last_win   = txn_win;
        next_arb   = cyc + 1;
      end
      if (!txn_active && cyc >= next_arb && bus.m_read != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          c = (last_win + k) % N;
          if (w < 0 && ((bus.m_read >> c) & N'(1)) != '0) w = c;
        end
        txn_win    = w;
        txn_addr   = AW'(bus.m_address >> (w * AW));
        t_start    = cyc;
        txn_active = 1'b1;
        txn_to     = 1'b0;
        t_end      = cyc + 2 + stall_cfg;
        txn_data   = slave_word(txn_addr);
`ifdef ARB_TIMEOUT_EN
        if (stall_cfg >= int'(TO)) begin
          t_end    = cyc + 1 + int'(TO);
          txn_data = '1;
          txn_to   = 1'b1;
        end
`endif
      end
    end
  end

  function automatic bit busy();
    bit b;
    b = txn_active;
    for (int i = 0; i < N; i++) if (pending[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input int maxc, input string nm);
    int n;
    n = 0;
    while (busy() && n < maxc) begin
      @(negedge clock); #1;
      n++;
    end
    total++;
    if (busy()) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles, need idle", nm, maxc);
    end
  endtask

  task automatic launch(input int p0, input int p1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        output int c0);
    @(negedge clock);
    bus.m_address = {a1, a0};
    pending[0]    = p0;
    pending[1]    = p1;
    @(negedge clock); #1;
    c0 = cyc;
  endtask

  task automatic check_entry(input string nm, input int idx, input int who, input int dc,
                             input logic [DW-1:0] d, input int c0);
    if (idx >= log_who.size()) begin
      total++;
      bad++;
      $display("FAIL %s: completion %0d missing, need master %0d", nm, idx, who);
    end else begin
      check({nm, "_who"},  64'(log_who[idx]),        64'(who));
      check({nm, "_cyc"},  64'(log_cyc[idx] - c0),   64'(dc));
      check({nm, "_data"}, 64'(log_data[idx]),       64'(d));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) pending[i] = 0;
    bus.m_read = '0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_s_read",    64'(bus.s_read),        64'(0));
    check("rst_s_address", 64'(bus.s_address),     64'(0));
    check("rst_readdata",  64'(bus.m_readdata),    64'(0));
    check("rst_waitreq",   64'(bus.m_waitrequest), 64'(2'b11));
    check("rst_grant",     64'(grant),             64'(0));
    check("rst_timeout",   64'(timeout_err),       64'(0));
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, need finish before 50000");
    $fatal(1);
  end

  initial begin
    int c0;
    int base;
    bus.m_read    = '0;
    bus.m_address = '0;
    for (int i = 0; i < N; i++) pending[i] = 0;
    #1;
    do_reset();

    // Single read by master 0 at address 1.
    launch(1, 0, 1'b1, 1'b0, c0);
    check("t1_c0_s_read",   64'(bus.s_read),        64'(0));
    @(negedge clock); #1;
    check("t1_c1_s_read",   64'(bus.s_read),        64'(1));
    check("t1_c1_grant",    64'(grant),             64'(2'b01));
    @(negedge clock); #1;
    check("t1_c2_waitreq",  64'(bus.m_waitrequest), 64'(2'b10));
    check("t1_c2_readdata", 64'(bus.m_readdata),    64'(ID_WORD));
    @(negedge clock); #1;
    check("t1_c3_waitreq",  64'(bus.m_waitrequest), 64'(2'b11));
    check("t1_c3_grant",    64'(grant),             64'(0));
    check("t1_c3_hold",     64'(bus.m_readdata),    64'(ID_WORD));
    wait_idle(20, "t1_idle");

    // Contention straight after reset, twice.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      base = log_who.size();
      launch(1, 1, 1'b1, 1'b0, c0);
      wait_idle(30, "t2_idle");
      check_entry("t2_first",  base,     0, 2, ID_WORD, c0);
      check_entry("t2_second", base + 1, 1, 5, '0,      c0);
    end

    // Fairness: both masters request continuously for 8 reads.
    base = log_who.size();
    launch(4, 4, 1'b0, 1'b1, c0);
    wait_idle(60, "t3_idle");
    for (int k = 0; k < 8; k++)
      check_entry("t3_rr", base + k, k % 2, 2 + 3 * k, (k % 2 == 1) ? ID_WORD : '0, c0);

    // Slave stalls for 4 cycles.
    stall_cfg = 4;
    base = log_who.size();
    launch(1, 0, 1'b1, 1'b0, c0);
    wait_idle(30, "t4_idle");
    stall_cfg = 0;
    check_entry("t4_stall", base, 0, 6, ID_WORD, c0);

    // Reset while the slave is being strobed.
    launch(1, 0, 1'b1, 1'b0, c0);
    @(negedge clock); #1;
    check("t5_issue_s_read", 64'(bus.s_read), 64'(1));
    #1;
    reset = 1'b1;
    #1;
    check("t5_async_s_read",  64'(bus.s_read),        64'(0));
    check("t5_async_waitreq", 64'(bus.m_waitrequest), 64'(2'b11));
    check("t5_async_grant",   64'(grant),             64'(0));
    base = log_who.size();
    do_reset();
    launch(1, 1, 1'b0, 1'b1, c0);
    wait_idle(30, "t5_idle");
    check_entry("t5_after_m0", base,     0, 2, '0,      c0);
    check_entry("t5_after_m1", base + 1, 1, 5, ID_WORD, c0);

`ifdef ARB_TIMEOUT_EN
    // Slave stuck busy: access abandoned after TO stalled cycles.
    stall_cfg = 1000;
    base = log_who.size();
    launch(1, 0, 1'b1, 1'b0, c0);
    wait_idle(40, "t6_idle");
    stall_cfg = 0;
    check_entry("t6_timeout", base, 0, 9, 32'hFFFFFFFF, c0);
    check("t6_err_set", 64'(timeout_err), 64'(1));
    launch(0, 1, 1'b0, 1'b1, c0);
    wait_idle(30, "t6_idle2");
    check_entry("t6_recover", base + 1, 1, 2, ID_WORD, c0);
    check("t6_err_sticky", 64'(timeout_err), 64'(1));
`else
    check("t6_err_tied", 64'(timeout_err), 64'(0));
`endif

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
